// File: rtl/punc_dump_pkg.sv
// rtl/punc_dump_pkg.sv - shared types, constants and helpers for the processor state dumper
// Optional feature macro: PUNC_DUMP_CKSUM_EN (adds the trailing checksum word and CKSUM state).
package punc_dump_pkg;

    localparam logic [15:0] HDR_WORD_DEFAULT = 16'hD0D0;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        PC,
        RF_SET,
        RF_OUT,
        MEM_SET,
        MEM_OUT,
        FIN
`ifdef PUNC_DUMP_CKSUM_EN
        , CKSUM
`endif
    } state_t;

    // Total number of words in one dump: header, PC, register file, memory (+ checksum).
    function automatic logic [31:0] stream_len(input int unsigned rf_regs,
                                               input logic [15:0] mem_count);
        logic [31:0] n;
        n = 32'd2 + 32'(rf_regs) + {16'd0, mem_count};
`ifdef PUNC_DUMP_CKSUM_EN
        n = n + 32'd1;
`endif
        return n;
    endfunction

endpackage

// File: rtl/punc_dump_cksum.sv
// rtl/punc_dump_cksum.sv - clear/accumulate 16-bit modulo-2^16 adder for the dump checksum
// Ports: clk, rst (async, active-high), clr (zero the sum), acc (add data), data[15:0], sum[15:0].
module punc_dump_cksum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        acc,
    input  logic [15:0] data,
    output logic [15:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 16'd0;
        end else if (clr) begin
            sum <= 16'd0;
        end else if (acc) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/punc_state_dumper.sv
// rtl/punc_state_dumper.sv - streams header, PC, register file and a memory window over a valid/ready port
// Ports: clk, rst (async, active-high); start, mem_base, mem_count (request);
//        mem_debug_addr, rf_debug_addr (to processor); mem_debug_data, rf_debug_data, pc_debug_data (from processor);
//        dump_valid, dump_ready, dump_data, dump_last (word stream); busy, done (status).
// Optional feature macro: PUNC_DUMP_CKSUM_EN appends a checksum word after the last data word.
module punc_state_dumper
    import punc_dump_pkg::*;
#(
    parameter int          RF_REGS  = 8,
    parameter logic [15:0] HDR_WORD = HDR_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mem_base,
    input  logic [15:0] mem_count,
    output logic [15:0] mem_debug_addr,
    output logic [2:0]  rf_debug_addr,
    input  logic [15:0] mem_debug_data,
    input  logic [15:0] rf_debug_data,
    input  logic [15:0] pc_debug_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_data,
    output logic        dump_last,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] RF_LAST = 3'(RF_REGS - 1);

    state_t      state, state_n;
    logic [15:0] data_q, data_n;
    logic        last_q, last_n;
    logic [15:0] base_q, base_n;
    logic [15:0] count_q, count_n;     // memory words still to emit, including the current one
    logic [15:0] mem_addr_q, mem_addr_n;
    logic [2:0]  rf_addr_q, rf_addr_n;
    logic        hs;

    assign dump_valid = (state == HDR) || (state == PC) || (state == RF_OUT) || (state == MEM_OUT)
`ifdef PUNC_DUMP_CKSUM_EN
                        || (state == CKSUM)
`endif
                        ;
    assign hs             = dump_valid && dump_ready;
    assign busy           = (state != IDLE) && (state != FIN);
    assign done           = (state == FIN);
    assign dump_last      = last_q;
    assign mem_debug_addr = mem_addr_q;
    assign rf_debug_addr  = rf_addr_q;

`ifdef PUNC_DUMP_CKSUM_EN
    logic [15:0] sum;

    // Every accepted word except the checksum itself feeds the sum; a new dump clears it.
    punc_dump_cksum u_cksum (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) && start),
        .acc  (hs && (state != CKSUM)),
        .data (dump_data),
        .sum  (sum)
    );

    assign dump_data = (state == CKSUM) ? sum : data_q;
`else
    assign dump_data = data_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_q     <= 16'd0;
            last_q     <= 1'b0;
            base_q     <= 16'd0;
            count_q    <= 16'd0;
            mem_addr_q <= 16'd0;
            rf_addr_q  <= 3'd0;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            last_q     <= last_n;
            base_q     <= base_n;
            count_q    <= count_n;
            mem_addr_q <= mem_addr_n;
            rf_addr_q  <= rf_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        data_n     = data_q;
        last_n     = last_q;
        base_n     = base_q;
        count_n    = count_q;
        mem_addr_n = mem_addr_q;
        rf_addr_n  = rf_addr_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = HDR;
                    data_n  = HDR_WORD;
                    last_n  = 1'b0;
                    base_n  = mem_base;
                    count_n = mem_count;
                end
            end
            HDR: begin
                if (hs) begin
                    state_n = PC;
                    data_n  = pc_debug_data;
                end
            end
            PC: begin
                if (hs) begin
                    state_n   = RF_SET;
                    rf_addr_n = 3'd0;
                end
            end
            RF_SET: begin
                // Address was driven during this cycle; the read data is valid at its end.
                state_n = RF_OUT;
                data_n  = rf_debug_data;
`ifdef PUNC_DUMP_CKSUM_EN
                last_n  = 1'b0;
`else
                last_n  = (rf_addr_q == RF_LAST) && (count_q == 16'd0);
`endif
            end
            RF_OUT: begin
                if (hs) begin
                    if (rf_addr_q != RF_LAST) begin
                        state_n   = RF_SET;
                        rf_addr_n = rf_addr_q + 3'd1;
                    end else if (count_q != 16'd0) begin
                        state_n    = MEM_SET;
                        mem_addr_n = base_q;
                    end else begin
`ifdef PUNC_DUMP_CKSUM_EN
                        state_n = CKSUM;
                        last_n  = 1'b1;
`else
                        state_n = FIN;
                        last_n  = 1'b0;
`endif
                    end
                end
            end
            MEM_SET: begin
                state_n = MEM_OUT;
                data_n  = mem_debug_data;
`ifdef PUNC_DUMP_CKSUM_EN
                last_n  = 1'b0;
`else
                last_n  = (count_q == 16'd1);
`endif
            end
            MEM_OUT: begin
                if (hs) begin
                    if (count_q != 16'd1) begin
                        state_n    = MEM_SET;
                        count_n    = count_q - 16'd1;
                        mem_addr_n = mem_addr_q + 16'd1;   // wraps modulo 2^16
                    end else begin
`ifdef PUNC_DUMP_CKSUM_EN
                        state_n = CKSUM;
                        last_n  = 1'b1;
`else
                        state_n = FIN;
                        last_n  = 1'b0;
`endif
                    end
                end
            end
`ifdef PUNC_DUMP_CKSUM_EN
            CKSUM: begin
                if (hs) begin
                    state_n = FIN;
                    last_n  = 1'b0;
                end
            end
`endif
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_punc_state_dumper.sv
// tb/tb_punc_state_dumper.sv - directed self-checking bench for punc_state_dumper
module tb_punc_state_dumper;
    import punc_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_base = 16'd0;
    logic [15:0] mem_count = 16'd0;
    logic [15:0] mem_debug_addr;
    logic [2:0]  rf_debug_addr;
    logic [15:0] mem_debug_data;
    logic [15:0] rf_debug_data;
    logic [15:0] pc_debug_data = 16'h3000;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [15:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    punc_state_dumper dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_base       (mem_base),
        .mem_count      (mem_count),
        .mem_debug_addr (mem_debug_addr),
        .rf_debug_addr  (rf_debug_addr),
        .mem_debug_data (mem_debug_data),
        .rf_debug_data  (rf_debug_data),
        .pc_debug_data  (pc_debug_data),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_data      (dump_data),
        .dump_last      (dump_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Processor debug read model: combinational reads
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h3000: return 16'h1234;
            16'h3001: return 16'h5678;
            16'hFFFF: return 16'hBEEF;
            16'h0000: return 16'hCAFE;
            default:  return ~a;
        endcase
    endfunction

    assign mem_debug_data = mem_word(mem_debug_addr);
    assign rf_debug_data  = {13'd0, rf_debug_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Negedge monitor: collects accepted words, done timing, address changes and stall stability
    logic [15:0] got_d[$];
    bit          got_l[$];
    logic [15:0] addr_q[$];
    int          cyc_n = 0;
    int          last_hs = -100;
    int          done_at = -1;
    int          done_cnt = 0;
    bit          saw_done = 0;
    bit          stalled = 0;
    logic [15:0] held_d;
    logic        held_l;
    logic [15:0] prev_addr = 16'd0;

    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            if (stalled) begin
                check("stall_valid", {31'd0, dump_valid}, 32'd1);
                check("stall_data", {16'd0, dump_data}, {16'd0, held_d});
                check("stall_last", {31'd0, dump_last}, {31'd0, held_l});
            end
            stalled = dump_valid && !dump_ready;
            held_d  = dump_data;
            held_l  = dump_last;
            if (dump_valid && dump_ready) begin
                got_d.push_back(dump_data);
                got_l.push_back(dump_last);
                if (dump_last) last_hs = cyc_n;
            end
            if (done) begin
                done_cnt++;
                saw_done = 1;
                done_at  = cyc_n;
            end
            if (mem_debug_addr != prev_addr) addr_q.push_back(mem_debug_addr);
        end else begin
            stalled = 0;
        end
        prev_addr = mem_debug_addr;
    end

    task automatic run_dump(input string tag, input logic [15:0] base, input logic [15:0] cnt,
                            input bit toggle, input bit extra_start, input logic [15:0] mem_exp[$]);
        logic [15:0] exp[$];
        logic [15:0] sum;
        logic [3:0]  pat;
        int          cyc;
        pat = 4'b1001;          // ready sequence 1,0,0,1 (bit 3 first)
        got_d.delete();
        got_l.delete();
        addr_q.delete();
        saw_done = 0;
        done_cnt = 0;
        dump_ready = 1'b1;
        mem_base = base;
        mem_count = cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!saw_done && cyc < 400) begin
            dump_ready = toggle ? pat[3 - (cyc % 4)] : 1'b1;
            start = (extra_start && cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        dump_ready = 1'b1;
        check({tag, "_timeout"}, {31'd0, saw_done}, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        exp.push_back(16'hD0D0);
        exp.push_back(16'h3000);
        for (int i = 0; i < 8; i++) exp.push_back(16'(i));
        foreach (mem_exp[i]) exp.push_back(mem_exp[i]);
`ifdef PUNC_DUMP_CKSUM_EN
        sum = 16'd0;
        foreach (exp[i]) sum = sum + exp[i];
        exp.push_back(sum);
`else
        sum = 16'd0;
`endif
        check({tag, "_len"}, got_d.size(), exp.size());
        check({tag, "_lenfn"}, stream_len(8, cnt), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_d.size()) begin
                check($sformatf("%s_w%0d", tag, i), {16'd0, got_d[i]}, {16'd0, exp[i]});
                check($sformatf("%s_l%0d", tag, i), {31'd0, got_l[i]}, (i == exp.size() - 1) ? 32'd1 : 32'd0);
            end
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_at, last_hs + 1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] m[$];
        int w;
        #1;
        check("rst_valid", {31'd0, dump_valid}, 32'd0);
        check("rst_data", {16'd0, dump_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_maddr", {16'd0, mem_debug_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scenario 1: basic dump of two memory words
        m = '{16'h1234, 16'h5678};
        run_dump("s1", 16'h3000, 16'd2, 0, 0, m);

        // Scenario 2: empty memory window; memory address must stay put
        m = '{};
        run_dump("s2", 16'h0100, 16'd0, 0, 0, m);
        check("s2_maddr_changes", addr_q.size(), 0);
        check("s2_maddr_hold", {16'd0, mem_debug_addr}, 32'h3001);

        // Scenario 3: ready toggling plus a start pulse while busy
        m = '{16'h1234, 16'h5678};
        run_dump("s3", 16'h3000, 16'd2, 1, 1, m);

        // Scenario 4: address wrap
        m = '{16'hBEEF, 16'hCAFE};
        run_dump("s4", 16'hFFFF, 16'd2, 0, 0, m);
        check("s4_naddr", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            check("s4_addr0", {16'd0, addr_q[0]}, 32'h0000FFFF);
            check("s4_addr1", {16'd0, addr_q[1]}, 32'h00000000);
        end

        // Scenario 5: reset in the middle of the register-file phase
        mem_base = 16'h3000;
        mem_count = 16'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (rf_debug_addr != 3'd3 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("s5_reach_rf3", {29'd0, rf_debug_addr}, 32'd3);
        check("s5_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("s5_valid", {31'd0, dump_valid}, 32'd0);
        check("s5_data", {16'd0, dump_data}, 32'd0);
        check("s5_last", {31'd0, dump_last}, 32'd0);
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_done", {31'd0, done}, 32'd0);
        check("s5_maddr", {16'd0, mem_debug_addr}, 32'd0);
        check("s5_raddr", {29'd0, rf_debug_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m = '{16'h1234, 16'h5678};
        run_dump("s5", 16'h3000, 16'd2, 0, 0, m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/punc_state_dumper.md
PUNC_STATE_DUMPER -- requirements
Module: punc_state_dumper

Interface
REQ-001 The parameter list SHALL be: RF_REGS, default 8, number of register-file entries dumped (R0..R7).
REQ-002 The parameter list SHALL be: HDR_WORD, default 16'hD0D0, first word of every dump.
REQ-003 There SHALL be one clock; reset is asynchronous and active-high, with port names as below.
REQ-004 clk  in  1  rising-edge clock shared with the processor.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a dump.
REQ-007 mem_base  in  16  first memory address to dump, sampled at start.
REQ-008 mem_count  in  16  number of memory words to dump, sampled at start.
REQ-009 mem_debug_addr  out  16  drives the processor memory debug address.
REQ-010 rf_debug_addr  out  3  drives the processor register-file debug address.
REQ-011 mem_debug_data / rf_debug_data / pc_debug_data  in  16 each  processor debug read data.
REQ-012 dump_valid, dump_ready, dump_data[15:0], dump_last  out/in/out/out  valid/ready output word stream.
REQ-013 busy  out  1  dump in progress; done  out  1  single-cycle pulse after the last word is accepted.

Function
REQ-014 The stream order SHALL be: HDR_WORD, PC, then R0..R(RF_REGS-1), then mem[mem_base .. mem_base+mem_count-1].
REQ-015 The FSM states SHALL be IDLE, HDR, PC, RF_SET, RF_OUT, MEM_SET, MEM_OUT, CKSUM, and FIN.
REQ-016 In IDLE, start=1 SHALL latch mem_base and mem_count, set busy, and enter HDR on the next edge.
REQ-017 start while busy SHALL be ignored.
REQ-018 In HDR, dump_valid=1 and dump_data=HDR_WORD SHALL hold until the handshake completes.
REQ-019 In PC, pc_debug_data SHALL be registered on entry and presented until accepted.
REQ-020 Each RF_SET/MEM_SET cycle SHALL drive the address; data SHALL be captured at the end of that cycle; the following *_OUT state SHALL present it.
REQ-021 This gives one setup cycle per register/memory word; with dump_ready held at 1 the pace is 2 cycles per word.
REQ-022 A handshake SHALL complete on the rising edge where dump_valid and dump_ready are both 1.
REQ-023 While dump_valid=1 and dump_ready=0, dump_data and dump_last SHALL be held stable.
REQ-024 dump_valid SHALL never drop without a completed handshake.
REQ-025 Memory address arithmetic SHALL be 16-bit modulo 2^16: base 16'hFFFF with count 2 reads FFFF then 0000.
REQ-026 With mem_count=0, no MEM states SHALL be visited; dump_last SHALL mark the final RF word (or the CKSUM word when enabled).
REQ-027 dump_last SHALL be 1 only on the final word of the stream.
REQ-028 FIN SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-029 A new start SHALL be accepted in the cycle after done.
REQ-030 The debug address outputs SHALL hold their last value outside the SET states.

Reset
REQ-031 Asserting rst at any time, including mid-dump, SHALL immediately force: state IDLE, busy=0, done=0, dump_valid=0, dump_last=0, dump_data=0, mem_debug_addr=0, rf_debug_addr=0, and checksum=0.
REQ-032 An interrupted dump SHALL NOT resume after reset.
REQ-033 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-034 Macro PUNC_DUMP_CKSUM_EN defined: after the last data word, CKSUM SHALL emit the 16-bit modulo-2^16 sum of all preceding words, header included; dump_last SHALL move to the CKSUM word.
REQ-035 Macro PUNC_DUMP_CKSUM_EN undefined: there SHALL be no CKSUM state, no accumulator, and no extra word.

Structure
REQ-036 Package punc_dump_pkg SHALL hold the FSM state enum, the HDR_WORD default constant, and the stream-length function 2+RF_REGS+mem_count(+1).
REQ-037 One sub-module, punc_dump_cksum, SHALL be used: a clear/accumulate 16-bit adder, instantiated only under PUNC_DUMP_CKSUM_EN.
REQ-038 The block SHALL sit downstream of the processor top, driving its debug address ports and consuming its debug data ports.

Verification
REQ-039 Scenario 1: ready=1, PC=16'h3000, Rn=n, base=16'h3000, count=2, mem={16'h1234,16'h5678} -> stream D0D0,3000,0..7,1234,5678; last on 5678; done one cycle later.
REQ-040 Scenario 2: count=0 -> 10 words; last on R7 (value 7); the memory debug address is never changed.
REQ-041 Scenario 3: ready toggling 1,0,0,1 -> no word is lost or duplicated, and data is stable while stalled.
REQ-042 Scenario 4: base=16'hFFFF, count=2 -> the addresses driven are FFFF then 0000.
REQ-043 Scenario 5: rst asserted mid-RF phase -> all outputs are 0 within the same cycle; a following start produces a complete fresh dump beginning with D0D0.
REQ-044 Scenario 6: with PUNC_DUMP_CKSUM_EN, scenario 1 -> an extra word equal to the 16-bit sum of the 12 prior words, last on that word; a start pulse during busy is ignored.
